instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- First stage of the 5-stage pipeline. Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents {pc, instruction, valid} to the decode stage under a valid/ready handshake, with a one-entry overflow buffer so a late memory ack never loses data.
- Accepts redirects (taken branch/jump) from execute and flushes all wrong-path work.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  read request; held high until imem_ack
imem_addr  out  32  word address of request; stable while imem_req=1 and no ack
imem_ack  in  1  read complete this cycle; imem_rdata valid; only sampled when imem_req=1
imem_rdata  in  32  instruction word
redirect  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  32  new PC; bits [1:0] are forced to 0
out_ready  in  1  decode accepts the output this cycle (!out_ready = stall)
out_valid  out  1  out_pc/out_instruction valid
out_pc  out  32  PC of presented instruction
out_instruction  out  32  presented instruction word

Behaviour:
- Registers:
  - pc: next fetch address
  - req_addr: address of the in-flight request
  - out_{valid,pc,instruction}
  - buf_{pc,instruction}
  - state
- Reset (async, any cycle, including mid-request):
  - state=FETCH, pc=req_addr=RESET_PC
  - out_valid=0, out_pc=0, out_instruction=0
  - buf cleared
  - A memory response outstanding at reset is the memory's responsibility; this block restarts cleanly.
- Outputs:
  - imem_req=1 in FETCH and DRAIN, 0 in FULL.
  - imem_addr=req_addr.
  - First request appears in the first cycle after reset deasserts, at RESET_PC.
- "Slot free" = !out_valid || out_ready. An output transfer occurs when out_valid && out_ready.
- FETCH, priority top-down:
  - redirect && !imem_ack: pc=req_addr=redirect_pc; out_valid=0; -> DRAIN (the old request must complete). req_addr then holds the redirect target while DRAIN keeps old address stable; see below.
  - redirect && imem_ack: drop the data; pc=req_addr=redirect_pc; out_valid=0; stay FETCH. New request issues the next cycle.
  - imem_ack && slot free: out<=(req_addr, rdata) with out_valid=1; pc=req_addr=req_addr+4; stay FETCH. Back-to-back acks give 1 instruction/cycle.
  - imem_ack && !slot free: buf<=(req_addr, rdata); pc=req_addr+4; -> FULL.
  - Otherwise: hold. A transfer with no ack clears out_valid.
- DRAIN:
  - imem_req=1, imem_addr = the old address, held in a separate drain_addr register captured on entry.
  - On imem_ack: discard data; req_addr=pc; -> FETCH.
  - Another redirect while in DRAIN updates pc (latest redirect wins).
  - out_valid stays 0.
- FULL:
  - imem_req=0; out stays stable while !out_ready.
  - On out_ready: out<=buf, out_valid=1; req_addr=pc; -> FETCH.
- Redirect has priority over out_ready in every state. A redirect in FULL clears out_valid and buf; pc=req_addr=redirect_pc; -> FETCH.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 wraps to 0.
- Latency: instruction visible on out_* the cycle after its imem_ack, minimum 2 cycles from request issue.
- Invariant: out_* never changes while out_valid && !out_ready && !redirect.

Decomposition:
- Add to cpu_types: typedef enum bit[1:0] { FETCH_REQ, FETCH_DRAIN, FETCH_FULL } fetch_state_t (prefixed to avoid clashing with the FETCH stage-index constant).
- Add to cpu_types: const bit [31:0] PC_STEP = 4.
- One sub-module is natural: fetch_skid_buffer, holding the out/buf register pair with its valid/ready logic. The FSM and PC stay in instruction_fetch_stage.

Test Plan:
- Reset, then memory acks every cycle, out_ready=1 -> imem_addr 0,4,8,...; out_pc 0,4,8 one cycle after each ack; out_valid continuous from cycle 2.
- Ack at 0x0 and 0x4 while out_ready=0 -> out holds (0x0, word0) stable, state FULL, imem_req=0. Raise out_ready -> 0x4 presented next cycle, then fetch resumes at 0x8.
- redirect=1, redirect_pc=0x100 while request to 0x8 is pending (ack 2 cycles later) -> imem_addr stays 0x8 until ack, data dropped, out_valid=0, next request 0x100.
- redirect and imem_ack same cycle, redirect_pc=0x203 -> ack data discarded, next imem_addr=0x200.
- PC at 0xFFFF_FFFC acked -> next imem_addr=0x0000_0000.
- rst asserted asynchronously mid-request with out_valid=1 -> out_valid=0 immediately; after release, imem_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: fetch FSM encoding and the PC increment.
package cpu_types;

  typedef enum bit [1:0] {
    FETCH_REQ,
    FETCH_DRAIN,
    FETCH_FULL
  } fetch_state_t;

  localparam bit [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/instruction_fetch_stage_skid.sv
// Output register plus one overflow entry between instruction memory and decode.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        capture,
  input  logic        pop,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction,
  output logic        slot_free
);

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (flush) begin
      out_valid_d = 1'b0;
      buf_pc_d    = '0;
      buf_instr_d = '0;
    end else if (pop) begin
      out_valid_d = 1'b1;
      out_pc_d    = buf_pc_q;
      out_instr_d = buf_instr_q;
    end else if (capture) begin
      // A late ack with a stalled output parks in the overflow entry
      if (slot_free) begin
        out_valid_d = 1'b1;
        out_pc_d    = in_pc;
        out_instr_d = in_instr;
      end else begin
        buf_pc_d    = in_pc;
        buf_instr_d = in_instr;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
      buf_pc_q    <= '0;
      buf_instr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instruction = out_instr_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues imem reads, handles redirects and hands
// instructions to decode through the skid buffer.
module instruction_fetch_stage
  import cpu_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instruction
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         flush, capture, pop, slot_free;
  logic [31:0]  redir_pc;
  logic         unused_redirect_lsbs;

  assign redir_pc             = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req  = (state_q != FETCH_FULL);
  assign imem_addr = (state_q == FETCH_DRAIN) ? drain_addr_q : req_addr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    drain_addr_d = drain_addr_q;
    flush        = 1'b0;
    capture      = 1'b0;
    pop          = 1'b0;
    unique case (state_q)
      FETCH_REQ: begin
        if (redirect && !imem_ack) begin
          // Old request must still complete; keep its address on the bus
          pc_d         = redir_pc;
          req_addr_d   = redir_pc;
          drain_addr_d = req_addr_q;
          flush        = 1'b1;
          state_d      = FETCH_DRAIN;
        end else if (redirect) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          flush      = 1'b1;
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_d    = req_addr_q + PC_STEP;
          if (slot_free) req_addr_d = req_addr_q + PC_STEP;
          else           state_d    = FETCH_FULL;
        end
      end
      FETCH_DRAIN: begin
        if (redirect) pc_d = redir_pc;
        if (imem_ack) begin
          req_addr_d = pc_d;
          state_d    = FETCH_REQ;
        end
      end
      FETCH_FULL: begin
        if (redirect) begin
          pc_d       = redir_pc;
          req_addr_d = redir_pc;
          flush      = 1'b1;
          state_d    = FETCH_REQ;
        end else if (out_ready) begin
          pop        = 1'b1;
          req_addr_d = pc_q;
          state_d    = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .capture         (capture),
    .pop             (pop),
    .in_pc           (req_addr_q),
    .in_instr        (imem_rdata),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .slot_free       (slot_free)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: expected {pc, word} pushed on
// each delivered ack, popped on every decode-side transfer.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Runs at posedge+1: score any transfer happening at the coming edge, then advance
  task automatic tick();
    exp_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("xfer_unexpected", out_pc, 32'hxxxx_xxxx);
      end else begin
        e = exp_q.pop_front();
        check_eq("xfer_pc", out_pc, e.pc);
        check_eq("xfer_instr", out_instruction, e.ins);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mem_ack(input logic [31:0] addr, input bit keep);
    check_eq("ack_req", {31'd0, imem_req}, 32'd1);
    check_eq("ack_addr", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = word_at(addr);
    if (keep) exp_q.push_back('{pc: addr, ins: word_at(addr)});
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_pc", out_pc, 32'd0);
    check_eq("rst_instr", out_instruction, 32'd0);
    rst = 1'b0;
    check_eq("first_req", {31'd0, imem_req}, 32'd1);
    check_eq("first_addr", imem_addr, 32'd0);

    // Streaming: one ack per cycle, decode always ready
    for (int i = 0; i < 5; i++) begin
      mem_ack(32'(4 * i), 1'b1);
      check_eq("stream_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stream_pc", out_pc, 32'(4 * i));
    end
    tick();
    check_eq("stream_idle", {31'd0, out_valid}, 32'd0);

    // Stall: second ack spills into the overflow entry
    out_ready = 1'b0;
    mem_ack(32'd20, 1'b1);
    mem_ack(32'd24, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check_eq("full_req", {31'd0, imem_req}, 32'd0);
      check_eq("full_hold_pc", out_pc, 32'd20);
      check_eq("full_hold_instr", out_instruction, word_at(32'd20));
      tick();
    end
    out_ready = 1'b1;
    tick();
    check_eq("unstall_pc", out_pc, 32'd24);
    check_eq("unstall_addr", imem_addr, 32'd28);
    mem_ack(32'd28, 1'b1);
    tick();

    // Redirect while a request is pending: old address drains first
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_eq("drain_addr", imem_addr, 32'd32);
      check_eq("drain_valid", {31'd0, out_valid}, 32'd0);
      if (i == 0) tick();
    end
    mem_ack(32'd32, 1'b0);
    check_eq("post_drain_valid", {31'd0, out_valid}, 32'd0);
    check_eq("post_drain_addr", imem_addr, 32'h100);
    mem_ack(32'h100, 1'b1);
    mem_ack(32'h104, 1'b1);

    // Redirect coincident with ack, misaligned target
    redirect = 1'b1; redirect_pc = 32'h203;
    mem_ack(32'h108, 1'b0);
    redirect = 1'b0;
    check_eq("redir_ack_valid", {31'd0, out_valid}, 32'd0);
    check_eq("redir_ack_addr", imem_addr, 32'h200);

    // Redirect while FULL flushes both presented and parked words
    out_ready = 1'b0;
    mem_ack(32'h200, 1'b0);
    check_eq("pre_full_pc", out_pc, 32'h200);
    mem_ack(32'h204, 1'b0);
    check_eq("pre_full_req", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    check_eq("full_redir_valid", {31'd0, out_valid}, 32'd0);
    check_eq("full_redir_req", {31'd0, imem_req}, 32'd1);
    check_eq("full_redir_addr", imem_addr, 32'hFFFF_FFF8);

    // PC wrap at the top of the address space
    out_ready = 1'b1;
    mem_ack(32'hFFFF_FFF8, 1'b1);
    mem_ack(32'hFFFF_FFFC, 1'b1);
    tick();
    check_eq("wrap_addr", imem_addr, 32'd0);

    // Async reset mid-cycle with a stalled valid output
    out_ready = 1'b0;
    mem_ack(32'd0, 1'b0);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("async_rst_instr", out_instruction, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rerst_req", {31'd0, imem_req}, 32'd1);
    check_eq("rerst_addr", imem_addr, 32'd0);
    out_ready = 1'b1;
    mem_ack(32'd0, 1'b1);
    tick();
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
